// File: rtl/cve2_instr_obi_responder.sv
// ---------------------------------------------------------------------------
// cve2_instr_obi_responder
// Responder side of the core's instruction fetch bus. It accepts OBI-style
// requests, drives a single-port fixed-latency instruction SRAM, and returns
// one in-order response per transfer. Fetches that are out of range or
// misaligned return a bus error.
//
// Optional feature macro: CVE2_IMEM_PARITY_EN
//   When defined, sram_rdata_i carries an even-parity bit in bit 32. A parity
//   failure on a legal response turns that response into an error, and the
//   extra output parity_err_o stays set until reset.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   instr_req_i      fetch request from the core
//   instr_addr_i     fetch byte address
//   instr_gnt_o      request accepted this cycle
//   instr_rvalid_o   response valid (exactly one cycle per transfer)
//   instr_rdata_o    response data, zero on error or when idle
//   instr_err_o      response is a bus error
//   sram_req_o       SRAM read strobe
//   sram_addr_o      SRAM word address, holds its last value when idle
//   sram_rdata_i     SRAM read data (33 bits with parity enabled)
//   parity_err_o     sticky parity failure flag (parity builds only)
//   busy_o           responses in flight or a grant wait in progress
// ---------------------------------------------------------------------------
module cve2_instr_obi_responder #(
   parameter logic [31:0] MemBaseAddr  = 32'h1000_0000,
   parameter logic [31:0] MemSizeBytes = 32'h0000_2000,
   parameter int unsigned SramLatency  = 1,
   parameter int unsigned WaitCycles   = 0,
   localparam int unsigned SramAw      = $clog2(MemSizeBytes / 4)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              instr_req_i,
   input  logic [31:0]       instr_addr_i,
   output logic              instr_gnt_o,
   output logic              instr_rvalid_o,
   output logic [31:0]       instr_rdata_o,
   output logic              instr_err_o,
   output logic              sram_req_o,
   output logic [SramAw-1:0] sram_addr_o,
`ifdef CVE2_IMEM_PARITY_EN
   input  logic [32:0]       sram_rdata_i,
   output logic              parity_err_o,
`else
   input  logic [31:0]       sram_rdata_i,
`endif
   output logic              busy_o
);

   logic in_wait;

   // Grant generation: pass-through when no wait states, otherwise a counter FSM
   if (WaitCycles == 0) begin : g_no_wait
      assign instr_gnt_o = instr_req_i;
      assign in_wait     = 1'b0;
   end else begin : g_wait
      localparam int unsigned CntW = (WaitCycles > 1) ? $clog2(WaitCycles) : 1;

      typedef enum logic {
         IDLE = 1'b0,
         WAIT = 1'b1
      } state_e;

      state_e          state_q, state_d;
      logic [CntW-1:0] cnt_q, cnt_d;
      logic            gnt;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // A dropped request abandons the wait; every new request waits in full
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         gnt     = 1'b0;
         case (state_q)
            IDLE: begin
               if (instr_req_i) begin
                  cnt_d   = CntW'(WaitCycles - 1);
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (!instr_req_i) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else if (cnt_q == '0) begin
                  gnt     = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      assign instr_gnt_o = gnt;
      assign in_wait     = (state_q == WAIT);
   end

   // Address decode; the mod-2^32 offset pushes addresses below the base out of range
   logic        xfer;
   logic        legal;
   logic [31:0] offset;

   assign offset     = instr_addr_i - MemBaseAddr;
   assign legal      = (offset < MemSizeBytes) && (instr_addr_i[1:0] == 2'b00);
   assign xfer       = instr_req_i && instr_gnt_o;
   assign sram_req_o = xfer && legal;

   // SRAM address register keeps the last issued word address
   logic [SramAw-1:0] sram_addr_q, sram_addr_d;

   assign sram_addr_d = sram_req_o ? offset[SramAw+1:2] : sram_addr_q;
   assign sram_addr_o = sram_addr_d;

   // Response pipeline: bit 0 is loaded at the grant, the top bit is the response
   logic [SramLatency-1:0] pipe_vld_q, pipe_vld_d;
   logic [SramLatency-1:0] pipe_err_q, pipe_err_d;

   always_comb begin
      pipe_vld_d = SramLatency'({pipe_vld_q, xfer});
      pipe_err_d = SramLatency'({pipe_err_q, xfer && !legal});
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_vld_q  <= '0;
         pipe_err_q  <= '0;
         sram_addr_q <= '0;
      end else begin
         pipe_vld_q  <= pipe_vld_d;
         pipe_err_q  <= pipe_err_d;
         sram_addr_q <= sram_addr_d;
      end
   end

   logic rsp_vld;
   logic rsp_tag_err;

   assign rsp_vld     = pipe_vld_q[SramLatency-1];
   assign rsp_tag_err = pipe_err_q[SramLatency-1];

`ifdef CVE2_IMEM_PARITY_EN
   // Even parity across all 33 bits must reduce to zero on a good read
   logic par_bad;
   logic parity_err_q, parity_err_d;

   assign par_bad      = rsp_vld && !rsp_tag_err && (^sram_rdata_i);
   assign parity_err_d = parity_err_q | par_bad;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err_o = parity_err_d;
   assign instr_err_o  = rsp_vld && (rsp_tag_err || par_bad);
`else
   assign instr_err_o  = rsp_vld && rsp_tag_err;
`endif

   assign instr_rvalid_o = rsp_vld;
   assign instr_rdata_o  = (rsp_vld && !instr_err_o) ? sram_rdata_i[31:0] : 32'h0;
   assign busy_o         = (|pipe_vld_q) || in_wait;

endmodule

// File: tb/tb_cve2_instr_obi_responder.sv
// ---------------------------------------------------------------------------
// tb_cve2_instr_obi_responder
// Four responder instances with different latency / wait settings share one
// stimulus stream. A cycle-level reference model (arrays keyed by due cycle)
// predicts grants, SRAM strobes and responses; the bench also plays the SRAM.
// Parity checks run when CVE2_IMEM_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_cve2_instr_obi_responder;

   localparam int          NI   = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] SIZE = 32'h0000_2000;
`ifdef CVE2_IMEM_PARITY_EN
   localparam int SRW = 33;
`else
   localparam int SRW = 32;
`endif

   function automatic int unsigned lat_of(input int g);
      return (g == 0) ? 1 : ((g == 2) ? 3 : 2);
   endfunction

   function automatic int unsigned wait_of(input int g);
      return (g == 3) ? 3 : 0;
   endfunction

   logic           clk = 1'b0;
   logic           rst_n;
   logic           req    [NI];
   logic [31:0]    addr   [NI];
   logic           gnt    [NI];
   logic           rvalid [NI];
   logic [31:0]    rdata  [NI];
   logic           err    [NI];
   logic           sreq   [NI];
   logic [10:0]    saddr  [NI];
   logic [SRW-1:0] srdata [NI];
   logic           busy   [NI];
`ifdef CVE2_IMEM_PARITY_EN
   logic           perr   [NI];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      cve2_instr_obi_responder #(
         .MemBaseAddr  (BASE),
         .MemSizeBytes (SIZE),
         .SramLatency  (lat_of(g)),
         .WaitCycles   (wait_of(g))
      ) u_dut (
         .clk_i          (clk),
         .rst_ni         (rst_n),
         .instr_req_i    (req[g]),
         .instr_addr_i   (addr[g]),
         .instr_gnt_o    (gnt[g]),
         .instr_rvalid_o (rvalid[g]),
         .instr_rdata_o  (rdata[g]),
         .instr_err_o    (err[g]),
         .sram_req_o     (sreq[g]),
         .sram_addr_o    (saddr[g]),
         .sram_rdata_i   (srdata[g]),
`ifdef CVE2_IMEM_PARITY_EN
         .parity_err_o   (perr[g]),
`endif
         .busy_o         (busy[g])
      );
   end

   // Reference model and SRAM environment state
   int             checks;
   int             errors;
   int             cyc;
   int             bad_word;
   logic [31:0]    mem    [2048];
   int unsigned    seen   [NI];
   logic [10:0]    last_w [NI];
   logic           sticky [NI];
   logic           exp_v  [NI][8];
   logic           exp_e  [NI][8];
   logic [10:0]    exp_w  [NI][8];
   logic           sch_v  [NI][8];
   logic [SRW-1:0] sch_d  [NI][8];

   task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s[%0d] cyc %0d: observed %h expected %h", tag, g, cyc, obs, expv);
      end
   endtask

   task automatic drive_all(input logic r, input logic [31:0] a);
      for (int g = 0; g < NI; g++) begin
         req[g]  = r;
         addr[g] = a;
      end
   endtask

   task automatic clear_model();
      for (int g = 0; g < NI; g++) begin
         seen[g]   = 0;
         last_w[g] = '0;
         sticky[g] = 1'b0;
         for (int s = 0; s < 8; s++) begin
            exp_v[g][s] = 1'b0;
            exp_e[g][s] = 1'b0;
            exp_w[g][s] = '0;
            sch_v[g][s] = 1'b0;
            sch_d[g][s] = '0;
         end
      end
   endtask

   // One clock cycle: inputs are already set (just after the rising edge)
   task automatic cycle();
      int          s;
      int          s2;
      logic        ge, legal, se, ve, ee, pbad, be;
      logic [31:0] off, de, d;
      s = cyc % 8;
      for (int g = 0; g < NI; g++) begin
         if (sch_v[g][s]) begin
            srdata[g]   = sch_d[g][s];
            sch_v[g][s] = 1'b0;
         end else begin
            srdata[g] = SRW'($urandom);
         end
      end
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         ge    = req[g] && (wait_of(g) == 0 || seen[g] == wait_of(g));
         off   = addr[g] - BASE;
         legal = (off < SIZE) && (addr[g][1:0] == 2'b00);
         se    = ge && legal;
         if (se) last_w[g] = off[12:2];
         ve   = exp_v[g][s];
         pbad = 1'b0;
`ifdef CVE2_IMEM_PARITY_EN
         pbad = ve && !exp_e[g][s] && (g == 0) && (int'(exp_w[g][s]) == bad_word);
`endif
         ee = ve && (exp_e[g][s] || pbad);
         de = (ve && !ee) ? mem[exp_w[g][s]] : 32'h0;
         be = (seen[g] != 0);
         for (int k = 0; k < 8; k++) be = be || exp_v[g][k];

         chk("gnt",    g, 32'(gnt[g]),    32'(ge));
         chk("sreq",   g, 32'(sreq[g]),   32'(se));
         chk("saddr",  g, 32'(saddr[g]),  32'(last_w[g]));
         chk("rvalid", g, 32'(rvalid[g]), 32'(ve));
         chk("err",    g, 32'(err[g]),    32'(ee));
         chk("rdata",  g, rdata[g],       de);
         chk("busy",   g, 32'(busy[g]),   32'(be));
`ifdef CVE2_IMEM_PARITY_EN
         sticky[g] = sticky[g] || pbad;
         chk("perr",   g, 32'(perr[g]),   32'(sticky[g]));
`endif

         // SRAM environment: return data lat cycles after each observed strobe
         if (sreq[g] === 1'b1) begin
            s2 = (cyc + int'(lat_of(g))) % 8;
            d  = mem[saddr[g]];
            sch_v[g][s2] = 1'b1;
`ifdef CVE2_IMEM_PARITY_EN
            sch_d[g][s2] = {(^d) ^ ((g == 0) && (int'(saddr[g]) == bad_word)), d};
`else
            sch_d[g][s2] = d;
`endif
         end

         exp_v[g][s] = 1'b0;
         if (ge) begin
            s2 = (cyc + int'(lat_of(g))) % 8;
            exp_v[g][s2] = 1'b1;
            exp_e[g][s2] = !legal;
            exp_w[g][s2] = off[12:2];
         end
         if (ge)          seen[g] = 0;
         else if (req[g]) seen[g] = seen[g] + 1;
         else             seen[g] = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear at once
   task automatic do_reset();
      drive_all(1'b0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      for (int g = 0; g < NI; g++) begin
         chk("rst_gnt",    g, 32'(gnt[g]),    32'h0);
         chk("rst_sreq",   g, 32'(sreq[g]),   32'h0);
         chk("rst_saddr",  g, 32'(saddr[g]),  32'h0);
         chk("rst_rvalid", g, 32'(rvalid[g]), 32'h0);
         chk("rst_err",    g, 32'(err[g]),    32'h0);
         chk("rst_rdata",  g, rdata[g],       32'h0);
         chk("rst_busy",   g, 32'(busy[g]),   32'h0);
`ifdef CVE2_IMEM_PARITY_EN
         chk("rst_perr",   g, 32'(perr[g]),   32'h0);
`endif
      end
      clear_model();
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc = cyc + 3;
   endtask

   initial begin
      logic [31:0] a;
      int          k;
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      bad_word = -1;
      rst_n    = 1'b1;
      for (int i = 0; i < 2048; i++) mem[i] = $urandom;
      mem[4] = 32'h0000_0013;
      for (int g = 0; g < NI; g++) srdata[g] = '0;
      drive_all(1'b0, 32'h0);
      clear_model();
      @(posedge clk);
      #1;
      do_reset();

      // Single fetch at 0x1000_0010
      drive_all(1'b1, 32'h1000_0010); cycle();
      drive_all(1'b0, 32'h0);         repeat (5) cycle();

      // Back-to-back stream of four words
      for (int i = 0; i < 4; i++) begin
         drive_all(1'b1, BASE + 32'(4 * i)); cycle();
      end
      drive_all(1'b0, 32'h0); repeat (5) cycle();

      // Out of range, misaligned, below base, wrapped, last legal word
      drive_all(1'b1, 32'h1000_2000); cycle();
      drive_all(1'b1, 32'h1000_0002); cycle();
      drive_all(1'b1, 32'h0FFF_FFFC); cycle();
      drive_all(1'b1, 32'hFFFF_FFFC); cycle();
      drive_all(1'b1, 32'h1000_1FFC); cycle();
      drive_all(1'b0, 32'h0);         repeat (5) cycle();

      // Held request (two waited grants), then a one-cycle abandoned request
      drive_all(1'b1, 32'h1000_0020); repeat (8) cycle();
      drive_all(1'b0, 32'h0);         repeat (4) cycle();
      drive_all(1'b1, 32'h1000_0024); cycle();
      drive_all(1'b0, 32'h0);         repeat (4) cycle();

      // Reset with two responses in flight
      drive_all(1'b1, 32'h1000_0030); cycle();
      drive_all(1'b1, 32'h1000_0034); cycle();
      do_reset();
      drive_all(1'b0, 32'h0);         repeat (6) cycle();

      // Randomised traffic, independent per instance
      repeat (400) begin
         for (int g = 0; g < NI; g++) begin
            k = int'($urandom_range(0, 9));
            if (k < 7)       a = BASE + {19'h0, 11'($urandom_range(0, 2047)), 2'b00};
            else if (k == 7) a = BASE + {19'h0, 11'($urandom_range(0, 2047)), 2'($urandom_range(1, 3))};
            else if (k == 8) a = BASE + SIZE + 32'($urandom_range(0, 255));
            else             a = $urandom;
            req[g]  = ($urandom_range(0, 9) < 7);
            addr[g] = a;
         end
         cycle();
      end
      drive_all(1'b0, 32'h0); repeat (5) cycle();

`ifdef CVE2_IMEM_PARITY_EN
      // Bad parity on word 7 of instance 0, then clean reads keep the flag set
      bad_word = 7;
      mem[7]   = 32'h0000_0001;
      drive_all(1'b1, 32'h1000_001C); cycle();
      drive_all(1'b0, 32'h0);         repeat (5) cycle();
      drive_all(1'b1, 32'h1000_0000); cycle();
      drive_all(1'b1, 32'h1000_0004); cycle();
      drive_all(1'b0, 32'h0);         repeat (5) cycle();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
